// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan scheduler: blank/drive slots, per-frame latch.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits 3..1.
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        slot_tick,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST =
    CW'(SCAN_DIV - BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_t;

  localparam state_t S_FIRST = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;

  state_t        r_state, w_state_n;
  logic [1:0]    r_idx, w_idx_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [15:0]   r_digits, w_digits_n;
  logic [3:0]    r_dpm, w_dpm_n;
  logic [6:0]    r_seg, w_seg_n;
  logic          r_dp, w_dp_n;
  logic [3:0]    r_an, w_an_n;
  logic          r_tick, w_tick_n;
  logic          r_fd, w_fd_n;
  logic [3:0]    w_nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic lz_blank(
    input logic [15:0] d,
    input logic [1:0]  i
  );
    logic b;
    case (i)
      2'd3: b = (d[15:12] == 4'h0);
      2'd2: b = (d[15:8] == 8'h00);
      2'd1: b = (d[15:4] == 12'h000);
      default: b = 1'b0;
    endcase
    return b;
  endfunction
`endif

  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_cnt_n    = r_cnt;
    w_digits_n = r_digits;
    w_dpm_n    = r_dpm;
    w_fd_n     = 1'b0;
    if (!enable) begin
      w_state_n = S_IDLE;
      w_idx_n   = 2'd0;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_n  = S_FIRST;
          w_idx_n    = 2'd0;
          w_cnt_n    = '0;
          w_digits_n = digits;
          w_dpm_n    = dp_mask;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_n = S_DRIVE;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == DRIVE_LAST) begin
            w_state_n = S_FIRST;
            w_cnt_n   = '0;
            w_idx_n   = r_idx + 2'd1;
            // Frame boundary: pick up new inputs only on the 3->0 wrap
            if (r_idx == 2'd3) begin
              w_digits_n = digits;
              w_dpm_n    = dp_mask;
              w_fd_n     = 1'b1;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_idx_n   = 2'd0;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_an_n   = 4'hF;
    w_seg_n  = 7'h7F;
    w_dp_n   = 1'b1;
    w_tick_n = 1'b0;
    w_nib    = w_digits_n[{w_idx_n, 2'b00} +: 4];
    if (w_state_n == S_DRIVE) begin
      w_an_n   = ~(4'b0001 << w_idx_n);
      w_seg_n  = decode(w_nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_blank(w_digits_n, w_idx_n))
        w_seg_n = 7'h7F;
`endif
      w_dp_n   = ~w_dpm_n[w_idx_n];
      w_tick_n = (w_cnt_n == '0);
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_digits <= 16'h0000;
      r_dpm    <= 4'h0;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
      r_an     <= 4'hF;
      r_tick   <= 1'b0;
      r_fd     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      r_cnt    <= w_cnt_n;
      r_digits <= w_digits_n;
      r_dpm    <= w_dpm_n;
      r_seg    <= w_seg_n;
      r_dp     <= w_dp_n;
      r_an     <= w_an_n;
      r_tick   <= w_tick_n;
      r_fd     <= w_fd_n;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign slot_tick  = r_tick;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: SCAN_DIV=8 with BLANK_CYC=2 and 0.
// Expected leading-zero behaviour follows LEADING_ZERO_BLANK_EN.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] dig;
  logic [3:0]  dpm;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;
  logic       tick_a, tick_b;
  logic       fd_a, fd_b;

  int passed = 0;
  int total  = 0;

  display_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) u_a (
    .clk_100MHz (clk),
    .reset      (rst_n),
    .enable     (en),
    .digits     (dig),
    .dp_mask    (dpm),
    .seg        (seg_a),
    .dp         (dp_a),
    .an         (an_a),
    .slot_tick  (tick_a),
    .frame_done (fd_a)
  );

  display_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(0)) u_b (
    .clk_100MHz (clk),
    .reset      (rst_n),
    .enable     (en),
    .digits     (dig),
    .dp_mask    (dpm),
    .seg        (seg_b),
    .dp         (dp_b),
    .an         (an_b),
    .slot_tick  (tick_b),
    .frame_done (fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic dark(input string tag);
    chk({tag, "_an"}, 16'(an_a), 16'hF);
    chk({tag, "_seg"}, 16'(seg_a), 16'h7F);
    chk({tag, "_dp"}, 16'(dp_a), 16'h1);
    chk({tag, "_tick"}, 16'(tick_a), 16'h0);
    chk({tag, "_fd"}, 16'(fd_a), 16'h0);
    chk({tag, "_an_nb"}, 16'(an_b), 16'hF);
  endtask

  // One 8-cycle slot: 2 blank cycles then 6 drive cycles on u_a;
  // u_b (no blank) drives the same digit for all 8 cycles.
  task automatic slot(input string tag, input logic [3:0] ae,
                      input logic [6:0] se, input logic de,
                      input logic fde, input logic chg);
    for (int c = 0; c < 8; c++) begin
      step();
      if (c < 2) begin
        chk({tag, "_blank_an"}, 16'(an_a), 16'hF);
        chk({tag, "_blank_seg"}, 16'(seg_a), 16'h7F);
      end else begin
        chk({tag, "_an"}, 16'(an_a), 16'(ae));
        chk({tag, "_seg"}, 16'(seg_a), 16'(se));
        chk({tag, "_dp"}, 16'(dp_a), 16'(de));
      end
      chk({tag, "_tick"}, 16'(tick_a), 16'(c == 2));
      chk({tag, "_fd"}, 16'(fd_a), 16'((c == 0) && fde));
      chk({tag, "_nb_an"}, 16'(an_b), 16'(ae));
      chk({tag, "_nb_seg"}, 16'(seg_b), 16'(se));
      chk({tag, "_nb_tick"}, 16'(tick_b), 16'(c == 0));
      chk({tag, "_nb_fd"}, 16'(fd_b), 16'((c == 0) && fde));
      if (chg && c == 4) dig = 16'hABCD;
    end
  endtask

  logic [6:0] lz_seg;

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lz_seg = 7'b1111111;
`else
    lz_seg = 7'b0000001;
`endif
    rst_n = 1'b0;
    en    = 1'b1;
    dig   = 16'h1234;
    dpm   = 4'b0010;
    step();
    step();
    dark("rst");
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    dark("idle");

    en = 1'b1;
    slot("f1d0", 4'b1110, 7'b1001100, 1'b1, 1'b0, 1'b0);
    slot("f1d1", 4'b1101, 7'b0000110, 1'b0, 1'b0, 1'b0);
    slot("f1d2", 4'b1011, 7'b0010010, 1'b1, 1'b0, 1'b0);
    slot("f1d3", 4'b0111, 7'b1001111, 1'b1, 1'b0, 1'b0);

    slot("f2d0", 4'b1110, 7'b1001100, 1'b1, 1'b1, 1'b0);
    slot("f2d1", 4'b1101, 7'b0000110, 1'b0, 1'b0, 1'b1);
    slot("f2d2", 4'b1011, 7'b0010010, 1'b1, 1'b0, 1'b0);
    slot("f2d3", 4'b0111, 7'b1001111, 1'b1, 1'b0, 1'b0);

    slot("f3d0", 4'b1110, 7'b1000010, 1'b1, 1'b1, 1'b0);
    slot("f3d1", 4'b1101, 7'b0110001, 1'b0, 1'b0, 1'b0);
    slot("f3d2", 4'b1011, 7'b1100000, 1'b1, 1'b0, 1'b0);
    slot("f3d3", 4'b0111, 7'b0001000, 1'b1, 1'b0, 1'b0);

    slot("f4d0", 4'b1110, 7'b1000010, 1'b1, 1'b1, 1'b0);
    slot("f4d1", 4'b1101, 7'b0110001, 1'b0, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("abort_pre_an", 16'(an_a), 16'b1011);
    en = 1'b0;
    step();
    dark("abort");
    for (int c = 0; c < 12; c++) begin
      step();
      chk("abort_fd", 16'(fd_a), 16'h0);
      chk("abort_an", 16'(an_a), 16'hF);
      chk("abort_nb_an", 16'(an_b), 16'hF);
    end
    en = 1'b1;
    slot("re_d0", 4'b1110, 7'b1000010, 1'b1, 1'b0, 1'b0);

    en = 1'b0;
    step();
    dig = 16'h0050;
    en  = 1'b1;
    slot("lz_d0", 4'b1110, 7'b0000001, 1'b1, 1'b0, 1'b0);
    slot("lz_d1", 4'b1101, 7'b0100100, 1'b0, 1'b0, 1'b0);
    slot("lz_d2", 4'b1011, lz_seg, 1'b1, 1'b0, 1'b0);
    slot("lz_d3", 4'b0111, lz_seg, 1'b1, 1'b0, 1'b0);
    slot("lz_w0", 4'b1110, 7'b0000001, 1'b1, 1'b1, 1'b0);

    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 16'(an_a), 16'hF);
    chk("async_rst_seg", 16'(seg_a), 16'h7F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
